rtdf_frame_parser: RTL and testbench

//  Header/length parser between the DM9000A controller RX FIFO and the real-time data

---
 rtl/rtdf_frame_parser_if.sv | 23 ++
 rtl/rtdf_frame_parser.sv | 137 +++++++++++++
 tb/tb_rtdf_frame_parser.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtdf_frame_parser_if.sv
// RX-FIFO read side and payload stream of the RTDF frame parser, bundled for port use.
interface rtdf_frame_parser_if;
    // Show-ahead FIFO: rx_fifo_rd_data is valid whenever rx_fifo_empty is low and
    // rx_fifo_rd_req pops it at the clock edge. The payload stream moves a word on
    // every edge where out_valid && out_ready; out_data/out_last hold while stalled.
    logic        rx_fifo_empty;
    logic [15:0] rx_fifo_rd_data;
    logic        rx_fifo_rd_req;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (
        input  rx_fifo_empty, rx_fifo_rd_data, out_ready,
        output rx_fifo_rd_req, out_valid, out_data, out_last
    );

    modport slave (
        output rx_fifo_empty, rx_fifo_rd_data, out_ready,
        input  rx_fifo_rd_req, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rtdf_frame_parser.sv
// Parses DM9000A RX FIFO frames: filters on destination, EtherType and length,
// strips header/sequence/CRC and streams payload words, keeping packet statistics.
module rtdf_frame_parser #(
    parameter logic [47:0] MY_MAC      = 48'h0012_3456_7890,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter logic [9:0]  MAX_PAYLOAD = 10'd736
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rtdf_frame_parser_if.master   bus,
    output logic [8:0]            packet_count,
    output logic [8:0]            good_packet_count,
    output logic [8:0]            seq_gap_count,
    output logic [2:0]            state_dbg
);

    localparam logic [15:0] MAX_LEN = 16'(2 * MAX_PAYLOAD + 20);

    typedef enum logic [2:0] {
        S_LEN     = 3'd0,
        S_HDR     = 3'd1,
        S_SEQ     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CRC     = 3'd4,
        S_DROP    = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] rem_cnt;     // frame words still in the FIFO for this frame
    logic [9:0]  word_cnt;
    logic        not_mine;
    logic        not_bcast;
    logic        first_good;
    logic [15:0] last_seq;

    logic        in_payload;
    logic        pop;
    logic [15:0] len_words;
    logic        len_ok;
    logic [15:0] mac_word;
    logic        hdr_not_mine;
    logic        hdr_not_bcast;
    logic [15:0] etype_rx;
    logic        hdr_reject;

    assign in_payload         = (state == S_PAYLOAD);
    assign bus.out_valid      = in_payload && !bus.rx_fifo_empty;
    assign bus.out_data       = in_payload ? bus.rx_fifo_rd_data : 16'd0;
    assign bus.out_last       = bus.out_valid && (rem_cnt == 16'd3);
    assign pop                = in_payload ? (bus.out_valid && bus.out_ready) : !bus.rx_fifo_empty;
    assign bus.rx_fifo_rd_req = pop;
    assign state_dbg          = state;

    // Frame word count rounds an odd byte count up to the padding word.
    assign len_words = 16'((17'(bus.rx_fifo_rd_data) + 17'd1) >> 1);
    assign len_ok    = !bus.rx_fifo_rd_data[0] && (bus.rx_fifo_rd_data >= 16'd22) &&
                       (bus.rx_fifo_rd_data <= MAX_LEN);

    // Bytes arrive little-endian within each FIFO word.
    always_comb begin
        mac_word = {MY_MAC[7:0], MY_MAC[15:8]};
        case (word_cnt[1:0])
            2'd0:    mac_word = {MY_MAC[39:32], MY_MAC[47:40]};
            2'd1:    mac_word = {MY_MAC[23:16], MY_MAC[31:24]};
            default: mac_word = {MY_MAC[7:0], MY_MAC[15:8]};
        endcase
    end

    assign hdr_not_mine  = not_mine  || ((word_cnt < 10'd3) && (bus.rx_fifo_rd_data != mac_word));
    assign hdr_not_bcast = not_bcast || ((word_cnt < 10'd3) && (bus.rx_fifo_rd_data != 16'hFFFF));
    assign etype_rx      = {bus.rx_fifo_rd_data[7:0], bus.rx_fifo_rd_data[15:8]};
    assign hdr_reject    = (hdr_not_mine && hdr_not_bcast) || (etype_rx != ETHERTYPE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_LEN;
            rem_cnt           <= 16'd0;
            word_cnt          <= 10'd0;
            not_mine          <= 1'b0;
            not_bcast         <= 1'b0;
            first_good        <= 1'b1;
            last_seq          <= 16'd0;
            packet_count      <= 9'd0;
            good_packet_count <= 9'd0;
            seq_gap_count     <= 9'd0;
        end else if (pop) begin
            case (state)
                S_LEN: begin
                    packet_count <= packet_count + 9'd1;
                    word_cnt     <= 10'd0;
                    not_mine     <= 1'b0;
                    not_bcast    <= 1'b0;
                    rem_cnt      <= len_words;
                    if (len_ok) begin
                        state <= S_HDR;
                    end else if (len_words != 16'd0) begin
                        state <= S_DROP;
                    end
                end
                S_HDR: begin
                    rem_cnt   <= rem_cnt - 16'd1;
                    word_cnt  <= word_cnt + 10'd1;
                    not_mine  <= hdr_not_mine;
                    not_bcast <= hdr_not_bcast;
                    if (word_cnt == 10'd6) begin
                        state <= hdr_reject ? S_DROP : S_SEQ;
                    end
                end
                S_SEQ: begin
                    rem_cnt           <= rem_cnt - 16'd1;
                    good_packet_count <= good_packet_count + 9'd1;
                    if (!first_good && (bus.rx_fifo_rd_data != last_seq + 16'd1)) begin
                        seq_gap_count <= seq_gap_count + 9'd1;
                    end
                    last_seq   <= bus.rx_fifo_rd_data;
                    first_good <= 1'b0;
                    state      <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    // Two CRC words trail the final payload word.
                    rem_cnt <= rem_cnt - 16'd1;
                    if (rem_cnt == 16'd3) begin
                        state <= S_CRC;
                    end
                end
                S_CRC, S_DROP: begin
                    rem_cnt <= rem_cnt - 16'd1;
                    if (rem_cnt == 16'd1) begin
                        state <= S_LEN;
                    end
                end
                default: state <= S_LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_rtdf_frame_parser.sv
// Bench for rtdf_frame_parser: FIFO driver, frame-level reference model feeding an
// expected-word queue, and a negedge monitor that pops and compares accepted words.
module tb_rtdf_frame_parser;

  localparam logic [47:0] MY_MAC  = 48'h0012_3456_7890;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETYPE   = 16'h88B5;
  localparam int          MAX_LEN = 2 * 736 + 20;

  logic       clk;
  logic       reset_n;
  logic [8:0] packet_count;
  logic [8:0] good_packet_count;
  logic [8:0] seq_gap_count;
  logic [2:0] state_dbg;

  rtdf_frame_parser_if bus_if ();

  rtdf_frame_parser dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .bus               (bus_if),
    .packet_count      (packet_count),
    .good_packet_count (good_packet_count),
    .seq_gap_count     (seq_gap_count),
    .state_dbg         (state_dbg)
  );

  logic [15:0] fifo_q[$];
  logic [16:0] exp_q[$];
  logic [15:0] pay_q[$];

  int          n_cmp;
  int          n_fail;
  int          m_packets;
  int          m_good;
  int          m_gap;
  bit          m_first;
  logic [15:0] m_last;
  bit          ready_rand;
  bit          gap_rand;
  bit          pop_pending;
  bit          stalled;
  logic [16:0] held;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO driver: pops the word the DUT took at the last edge, then presents the next head
  initial begin
    bus_if.rx_fifo_empty   = 1'b1;
    bus_if.rx_fifo_rd_data = 16'd0;
    bus_if.out_ready       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && reset_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus_if.rx_fifo_empty   = (fifo_q.size() == 0) || (gap_rand && $urandom_range(0, 3) == 0);
      bus_if.rx_fifo_rd_data = !bus_if.rx_fifo_empty ? fifo_q[0] : 16'($urandom);
      bus_if.out_ready       = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset_n) begin
      pop_pending = 1'b0;
      stalled     = 1'b0;
      check("valid_in_reset", 32'(bus_if.out_valid), 32'd0);
    end else begin
      pop_pending = bus_if.rx_fifo_rd_req;
      if (bus_if.rx_fifo_rd_req) check("pop_while_empty", 32'(bus_if.rx_fifo_empty), 32'd0);
      if (stalled && bus_if.out_valid)
        check("hold_stable", 32'({bus_if.out_last, bus_if.out_data}), 32'(held));
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'({bus_if.out_last, bus_if.out_data}), 32'h1ffff);
        end else begin
          e = exp_q.pop_front();
          check("payload_word", 32'({bus_if.out_last, bus_if.out_data}), 32'(e));
        end
      end
      stalled = bus_if.out_valid && !bus_if.out_ready;
      held    = {bus_if.out_last, bus_if.out_data};
    end
  end

  // Reference model: builds the byte-level frame and decides acceptance from the frame rules
  task automatic send_frame(input logic [47:0] dest, input logic [15:0] etype,
                            input logic [15:0] seq, input int l);
    int          w;
    int          p;
    bit          ok;
    bit          accept;
    logic [15:0] wd;
    w = (l + 1) / 2;
    fifo_q.push_back(16'(l));
    ok = (l % 2 == 0) && (l >= 22) && (l <= MAX_LEN);
    accept = ok && (dest == MY_MAC || dest == BCAST) && (etype == ETYPE);
    if (!ok) begin
      for (int i = 0; i < w; i++) fifo_q.push_back(16'($urandom));
    end else begin
      for (int k = 0; k < 3; k++) fifo_q.push_back({dest[39-16*k -: 8], dest[47-16*k -: 8]});
      for (int k = 0; k < 3; k++) fifo_q.push_back(16'($urandom));
      fifo_q.push_back({etype[7:0], etype[15:8]});
      fifo_q.push_back(seq);
      p = (l - 20) / 2;
      for (int i = 0; i < p; i++) begin
        wd = (pay_q.size() > 0) ? pay_q.pop_front() : 16'($urandom);
        fifo_q.push_back(wd);
        if (accept) exp_q.push_back({(i == p - 1), wd});
      end
      fifo_q.push_back(16'($urandom));
      fifo_q.push_back(16'($urandom));
    end
    m_packets++;
    if (accept) begin
      m_good++;
      if (!m_first && seq != 16'(m_last + 16'd1)) m_gap++;
      m_last  = seq;
      m_first = 1'b0;
    end
    pay_q.delete();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_drain: got %0d words left expected 0", name, fifo_q.size() + exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_packets"}, 32'(packet_count), 32'(9'(m_packets)));
    check({name, "_good"}, 32'(good_packet_count), 32'(9'(m_good)));
    check({name, "_gap"}, 32'(seq_gap_count), 32'(9'(m_gap)));
  endtask

  task automatic model_reset();
    m_packets = 0;
    m_good    = 0;
    m_gap     = 0;
    m_first   = 1'b1;
    m_last    = 16'd0;
  endtask

  logic [47:0] r_dest;
  logic [15:0] r_etype;
  logic [15:0] r_seq;
  int          r_len;
  int          r_kind;
  int          t_wait;

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    ready_rand = 1'b0;
    gap_rand   = 1'b0;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_packets", 32'(packet_count), 32'd0);
    check("rst_good", 32'(good_packet_count), 32'd0);
    check("rst_gap", 32'(seq_gap_count), 32'd0);
    check("rst_rd_req", 32'(bus_if.rx_fifo_rd_req), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    pay_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_frame(MY_MAC, ETYPE, 16'd5, 28);
    drain("good_frame");

    send_frame(MY_MAC, 16'h0800, 16'd6, 28);
    drain("bad_etype");
    send_frame(MY_MAC, ETYPE, 16'd7, 28);
    drain("after_bad_etype");

    send_frame(MY_MAC, ETYPE, 16'd8, 27);
    send_frame(MY_MAC, ETYPE, 16'd8, 18);
    drain("odd_short_len");

    send_frame(MY_MAC, ETYPE, 16'd8, 30);
    drain("seq_no_gap");

    ready_rand = 1'b1;
    gap_rand   = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(MY_MAC, ETYPE, 16'(m_last + 16'd1), 60);
    drain("stall");

    for (int i = 0; i < 40; i++) begin
      r_kind  = $urandom_range(0, 9);
      r_len   = 2 * $urandom_range(11, 70);
      r_dest  = MY_MAC;
      r_etype = ETYPE;
      r_seq   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(m_last + 16'd1);
      case (r_kind)
        0: r_dest  = 48'({$urandom(), $urandom()});
        1: r_dest  = BCAST;
        2: r_etype = 16'($urandom);
        3: r_len   = r_len + 1;
        4: r_len   = $urandom_range(1, 21);
        default: ;
      endcase
      send_frame(r_dest, r_etype, r_seq, r_len);
    end
    drain("random");

    ready_rand = 1'b0;
    gap_rand   = 1'b0;
    send_frame(MY_MAC, ETYPE, 16'h0100, MAX_LEN);
    send_frame(MY_MAC, ETYPE, 16'h0101, MAX_LEN + 2);
    send_frame(MY_MAC, ETYPE, 16'h0101, 20);
    send_frame(MY_MAC, ETYPE, 16'h0101, 21);
    send_frame(BCAST, ETYPE, 16'h0101, 22);
    send_frame(MY_MAC, ETYPE, 16'hffff, 22);
    send_frame(MY_MAC, ETYPE, 16'h0000, 22);
    drain("boundaries");

    for (int i = 0; i < 520; i++) send_frame(MY_MAC, ETYPE, 16'd0, 1);
    drain("counter_wrap");

    send_frame(MY_MAC, ETYPE, 16'h0200, 100);
    t_wait = 0;
    do begin
      @(negedge clk);
      t_wait++;
    end while (!(bus_if.out_valid && exp_q.size() < 38) && t_wait < 2000);
    check("reset_reached_payload", 32'(bus_if.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    model_reset();
    #1;
    check("async_rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("async_rst_packets", 32'(packet_count), 32'd0);
    check("async_rst_good", 32'(good_packet_count), 32'd0);
    check("async_rst_gap", 32'(seq_gap_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_frame(MY_MAC, ETYPE, 16'd1000, 40);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
